// File: rtl/issue_operand_ctrl_pkg.sv
// Shared widths and small helpers for the issue-stage operand sequencer.
package issue_operand_ctrl_pkg;

    localparam int unsigned RegIdxW        = 5;
    localparam int unsigned XLen           = 32;
    localparam int unsigned RobIdxWDefault = 4;

    // An operand only needs resolving when it is used and is not the hardwired x0.
    function automatic logic operand_live(input logic use_rs, input logic [RegIdxW-1:0] rs);
        return use_rs && (rs != '0);
    endfunction

endpackage

// File: rtl/issue_operand_resolve.sv
// Combinational priority mux resolving one operand: x0/unused, RF value, ROB result, CDB0, CDB1.
module issue_operand_resolve
    import issue_operand_ctrl_pkg::*;
#(
    parameter int unsigned ROB_IDX_W = RobIdxWDefault
) (
    input  logic                 use_i,
    input  logic                 has_dep_i,
    input  logic [XLen-1:0]      val_i,
    input  logic [ROB_IDX_W-1:0] dep_i,
    input  logic                 rob_rdy_i,
    input  logic [XLen-1:0]      rob_val_i,
    input  logic                 cdb0_valid_i,
    input  logic [ROB_IDX_W-1:0] cdb0_rob_id_i,
    input  logic [XLen-1:0]      cdb0_val_i,
    input  logic                 cdb1_valid_i,
    input  logic [ROB_IDX_W-1:0] cdb1_rob_id_i,
    input  logic [XLen-1:0]      cdb1_val_i,
    output logic                 q_valid_o,
    output logic [ROB_IDX_W-1:0] q_o,
    output logic [XLen-1:0]      v_o
);

    always_comb begin
        q_valid_o = 1'b0;
        q_o       = '0;
        v_o       = '0;
        if (!use_i) begin
            v_o = '0;
        end else if (!has_dep_i) begin
            v_o = val_i;
        end else if (rob_rdy_i) begin
            v_o = rob_val_i;
        end else if (cdb0_valid_i && (cdb0_rob_id_i == dep_i)) begin
            v_o = cdb0_val_i;
        end else if (cdb1_valid_i && (cdb1_rob_id_i == dep_i)) begin
            v_o = cdb1_val_i;
        end else begin
            q_valid_o = 1'b1;
            q_o       = dep_i;
        end
    end

endmodule

// File: rtl/issue_operand_ctrl.sv
// Issue-stage operand sequencer: RF reads, rd renaming, operand resolution and a single-entry
// output packet register that keeps snooping the CDB while stalled.
module issue_operand_ctrl
    import issue_operand_ctrl_pkg::*;
#(
    parameter int unsigned ROB_IDX_W = RobIdxWDefault
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RegIdxW-1:0]   in_rs1,
    input  logic [RegIdxW-1:0]   in_rs2,
    input  logic [RegIdxW-1:0]   in_rd,
    input  logic                 in_use_rs1,
    input  logic                 in_use_rs2,
    input  logic [ROB_IDX_W-1:0] in_rob_id,
    output logic [RegIdxW-1:0]   rf_req_id1,
    output logic [RegIdxW-1:0]   rf_req_id2,
    input  logic [XLen-1:0]      rf_val1,
    input  logic [XLen-1:0]      rf_val2,
    input  logic [ROB_IDX_W-1:0] rf_dep1,
    input  logic [ROB_IDX_W-1:0] rf_dep2,
    input  logic                 rf_has_dep1,
    input  logic                 rf_has_dep2,
    output logic [RegIdxW-1:0]   rf_set_dep_id,
    output logic [ROB_IDX_W-1:0] rf_set_dep,
    output logic [ROB_IDX_W-1:0] rob_qry_id1,
    output logic [ROB_IDX_W-1:0] rob_qry_id2,
    input  logic                 rob_qry_rdy1,
    input  logic                 rob_qry_rdy2,
    input  logic [XLen-1:0]      rob_qry_val1,
    input  logic [XLen-1:0]      rob_qry_val2,
    input  logic                 cdb0_valid,
    input  logic                 cdb1_valid,
    input  logic [ROB_IDX_W-1:0] cdb0_rob_id,
    input  logic [ROB_IDX_W-1:0] cdb1_rob_id,
    input  logic [XLen-1:0]      cdb0_val,
    input  logic [XLen-1:0]      cdb1_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROB_IDX_W-1:0] out_rob_id,
    output logic [RegIdxW-1:0]   out_rd,
    output logic                 out_qj_valid,
    output logic                 out_qk_valid,
    output logic [ROB_IDX_W-1:0] out_qj,
    output logic [ROB_IDX_W-1:0] out_qk,
    output logic [XLen-1:0]      out_vj,
    output logic [XLen-1:0]      out_vk
);

    logic                 valid_q, valid_d;
    logic [ROB_IDX_W-1:0] rob_id_q, rob_id_d;
    logic [RegIdxW-1:0]   rd_q, rd_d;
    logic                 qj_valid_q, qj_valid_d, qk_valid_q, qk_valid_d;
    logic [ROB_IDX_W-1:0] qj_q, qj_d, qk_q, qk_d;
    logic [XLen-1:0]      vj_q, vj_d, vk_q, vk_d;

    logic                 accept;
    logic                 new_qj_valid, new_qk_valid, wake_qj_valid, wake_qk_valid;
    logic [ROB_IDX_W-1:0] new_qj, new_qk, wake_qj, wake_qk;
    logic [XLen-1:0]      new_vj, new_vk, wake_vj, wake_vk;

    assign in_ready = !rst_in && rdy_in && !clear && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign rf_req_id1  = in_rs1;
    assign rf_req_id2  = in_rs2;
    assign rob_qry_id1 = rf_dep1;
    assign rob_qry_id2 = rf_dep2;

    // RF reads this cycle still return the pre-rename dep, so rs == rd sees the older producer.
    assign rf_set_dep_id = (accept && (in_rd != '0)) ? in_rd : '0;
    assign rf_set_dep    = (accept && (in_rd != '0)) ? in_rob_id : '0;

    issue_operand_resolve #(.ROB_IDX_W(ROB_IDX_W)) u_resolve_j (
        .use_i        (operand_live(in_use_rs1, in_rs1)),
        .has_dep_i    (rf_has_dep1),
        .val_i        (rf_val1),
        .dep_i        (rf_dep1),
        .rob_rdy_i    (rob_qry_rdy1),
        .rob_val_i    (rob_qry_val1),
        .cdb0_valid_i (cdb0_valid),
        .cdb0_rob_id_i(cdb0_rob_id),
        .cdb0_val_i   (cdb0_val),
        .cdb1_valid_i (cdb1_valid),
        .cdb1_rob_id_i(cdb1_rob_id),
        .cdb1_val_i   (cdb1_val),
        .q_valid_o    (new_qj_valid),
        .q_o          (new_qj),
        .v_o          (new_vj)
    );

    issue_operand_resolve #(.ROB_IDX_W(ROB_IDX_W)) u_resolve_k (
        .use_i        (operand_live(in_use_rs2, in_rs2)),
        .has_dep_i    (rf_has_dep2),
        .val_i        (rf_val2),
        .dep_i        (rf_dep2),
        .rob_rdy_i    (rob_qry_rdy2),
        .rob_val_i    (rob_qry_val2),
        .cdb0_valid_i (cdb0_valid),
        .cdb0_rob_id_i(cdb0_rob_id),
        .cdb0_val_i   (cdb0_val),
        .cdb1_valid_i (cdb1_valid),
        .cdb1_rob_id_i(cdb1_rob_id),
        .cdb1_val_i   (cdb1_val),
        .q_valid_o    (new_qk_valid),
        .q_o          (new_qk),
        .v_o          (new_vk)
    );

    // Held operands go back through the same mux with the ROB path disabled: a resolved
    // operand passes its value through, a pending one picks up a matching broadcast.
    issue_operand_resolve #(.ROB_IDX_W(ROB_IDX_W)) u_wake_j (
        .use_i        (1'b1),
        .has_dep_i    (qj_valid_q),
        .val_i        (vj_q),
        .dep_i        (qj_q),
        .rob_rdy_i    (1'b0),
        .rob_val_i    ('0),
        .cdb0_valid_i (cdb0_valid),
        .cdb0_rob_id_i(cdb0_rob_id),
        .cdb0_val_i   (cdb0_val),
        .cdb1_valid_i (cdb1_valid),
        .cdb1_rob_id_i(cdb1_rob_id),
        .cdb1_val_i   (cdb1_val),
        .q_valid_o    (wake_qj_valid),
        .q_o          (wake_qj),
        .v_o          (wake_vj)
    );

    issue_operand_resolve #(.ROB_IDX_W(ROB_IDX_W)) u_wake_k (
        .use_i        (1'b1),
        .has_dep_i    (qk_valid_q),
        .val_i        (vk_q),
        .dep_i        (qk_q),
        .rob_rdy_i    (1'b0),
        .rob_val_i    ('0),
        .cdb0_valid_i (cdb0_valid),
        .cdb0_rob_id_i(cdb0_rob_id),
        .cdb0_val_i   (cdb0_val),
        .cdb1_valid_i (cdb1_valid),
        .cdb1_rob_id_i(cdb1_rob_id),
        .cdb1_val_i   (cdb1_val),
        .q_valid_o    (wake_qk_valid),
        .q_o          (wake_qk),
        .v_o          (wake_vk)
    );

    assign out_valid    = valid_q;
    assign out_rob_id   = rob_id_q;
    assign out_rd       = rd_q;
    assign out_qj_valid = wake_qj_valid;
    assign out_qj       = wake_qj;
    assign out_vj       = wake_vj;
    assign out_qk_valid = wake_qk_valid;
    assign out_qk       = wake_qk;
    assign out_vk       = wake_vk;

    always_comb begin
        valid_d    = valid_q;
        rob_id_d   = rob_id_q;
        rd_d       = rd_q;
        qj_valid_d = qj_valid_q;
        qj_d       = qj_q;
        vj_d       = vj_q;
        qk_valid_d = qk_valid_q;
        qk_d       = qk_q;
        vk_d       = vk_q;
        if (rdy_in) begin
            if (clear) begin
                valid_d = 1'b0;
            end else if (accept) begin
                valid_d    = 1'b1;
                rob_id_d   = in_rob_id;
                rd_d       = in_rd;
                qj_valid_d = new_qj_valid;
                qj_d       = new_qj;
                vj_d       = new_vj;
                qk_valid_d = new_qk_valid;
                qk_d       = new_qk;
                vk_d       = new_vk;
            end else if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end else if (valid_q) begin
                qj_valid_d = wake_qj_valid;
                qj_d       = wake_qj;
                vj_d       = wake_vj;
                qk_valid_d = wake_qk_valid;
                qk_d       = wake_qk;
                vk_d       = wake_vk;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q    <= 1'b0;
            rob_id_q   <= '0;
            rd_q       <= '0;
            qj_valid_q <= 1'b0;
            qj_q       <= '0;
            vj_q       <= '0;
            qk_valid_q <= 1'b0;
            qk_q       <= '0;
            vk_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            rob_id_q   <= rob_id_d;
            rd_q       <= rd_d;
            qj_valid_q <= qj_valid_d;
            qj_q       <= qj_d;
            vj_q       <= vj_d;
            qk_valid_q <= qk_valid_d;
            qk_q       <= qk_d;
            vk_q       <= vk_d;
        end
    end

endmodule

// File: doc/issue_operand_ctrl.md
Name: issue_operand_ctrl

Overview:
- Sequences the register file's two read ports and its dependency-write port for the issue stage of the out-of-order core.
- Accepts one decoded instruction per cycle and reads rs1/rs2 value, dep and has_dep from the register file.
- Resolves each operand against ROB-ready values and same-cycle CDB broadcasts, and marks rd as renamed to the instruction's ROB id.
- Hands a registered operand packet to the RS/LSB dispatch logic, and keeps snooping the CDB while the packet is stalled.

Parameters:
- ROB_IDX_W, 4, ROB index width; must equal `ROB_INDEX_BIT` from const.v.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low = freeze
- clear  in  1  mispredict flush
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_use_rs1, in_use_rs2  in  1 each  operand used
- in_rob_id  in  ROB_IDX_W  ROB slot of instruction
- rf_req_id1, rf_req_id2  out  5 each  RF read indices (combinational from in_rs1/in_rs2)
- rf_val1, rf_val2  in  32 each  RF values
- rf_dep1, rf_dep2  in  ROB_IDX_W each  RF dependencies
- rf_has_dep1, rf_has_dep2  in  1 each  RF dependency flags
- rf_set_dep_id  out  5  rd to rename (0 = none)
- rf_set_dep  out  ROB_IDX_W  ROB id written as dependency
- rob_qry_id1, rob_qry_id2  out  ROB_IDX_W each  ROB query slots (= rf_dep1/rf_dep2)
- rob_qry_rdy1, rob_qry_rdy2  in  1 each  queried entry has result
- rob_qry_val1, rob_qry_val2  in  32 each  queried entry result
- cdb0_valid, cdb1_valid  in  1 each  ALU/LSB broadcast valid
- cdb0_rob_id, cdb1_rob_id  in  ROB_IDX_W each  broadcast tag
- cdb0_val, cdb1_val  in  32 each  broadcast value
- out_valid  out  1  packet valid
- out_ready  in  1  downstream accepts
- out_rob_id  out  ROB_IDX_W
- out_rd  out  5
- out_qj_valid, out_qk_valid  out  1 each  operand still pending
- out_qj, out_qk  out  ROB_IDX_W each  pending tags
- out_vj, out_vk  out  32 each  operand values

Behaviour:
- Reset: out_valid=0, all packet registers 0, rf_set_dep_id=0, in_ready=0 during the reset cycle.
- in_ready = rdy_in && !clear && (!out_valid || out_ready). Single-entry pipeline register; accept at cycle t gives out_valid at t+1.
- Per-operand resolution at accept, in priority order (k uses rs2 with the same rules):
  - 1. !use or rs==0: v=0, q_valid=0.
  - 2. !rf_has_dep: v=rf_val.
  - 3. rob_qry_rdy: v=rob_qry_val.
  - 4. cdb0 tag match: v=cdb0_val.
  - 5. cdb1 tag match: v=cdb1_val.
  - 6. Otherwise q_valid=1, q=rf_dep.
- Renaming at accept:
  - rf_set_dep_id=in_rd and rf_set_dep=in_rob_id in the accept cycle only; 0 otherwise.
  - rd==0 gives 0.
  - Reads in the same cycle see the pre-rename dep, so rs==rd correctly depends on the older producer.
- Hold/wakeup: while out_valid && q_valid, a CDB tag match clears q_valid and latches the value at the next edge.
- Handoff-cycle forwarding: out_q*_valid and out_v* are combinationally overridden by a CDB match in the same cycle, so a packet consumed during a broadcast is already resolved.
- Handoff: out_valid && out_ready with no new accept gives out_valid=0 next cycle. Handoff plus accept in the same cycle loads the new packet back-to-back.
- clear (rdy_in high): out_valid=0 next edge, no accept, rf_set_dep_id=0. clear has priority over all other activity.
- rdy_in low: all state frozen, no accept, rf_set_dep_id=0, outputs hold.
- Simultaneous matches on cdb0 and cdb1 with the same tag cannot happen; if they do, cdb0 wins.
- A mid-operation reset discards any held packet.

Decomposition:
- Shared constants stay in const.v: ROB_INDEX_BIT and CDB port count.
- One natural sub-module, operand_resolve: a purely combinational priority mux (x0/RF/ROB/CDB), instantiated twice for rs1 and rs2 and reused for the hold-wakeup check.

Test Plan:
- Reset, then issue add x3,x1,x2 (rob 2) with the RF holding x1=5, x2=7 and no deps -> next cycle out_valid=1, vj=5, vk=7, q*_valid=0; rf_set_dep_id=3, rf_set_dep=2 during the accept cycle.
- x1 dep=4 with ROB slot 4 ready (val 0x11) -> vj=0x11, qj_valid=0.
- x1 dep=4 not ready and cdb1 broadcasts rob 4 = 0x22 in the accept cycle -> vj=0x22, qj_valid=0.
- x1 dep=4 pending with out_ready=0 for 3 cycles; cdb0 broadcasts rob 4 = 9 on cycle 2 -> from cycle 3 qj_valid=0, vj=9. Repeat with out_ready=1 in the broadcast cycle -> consumed packet shows qj_valid=0, vj=9.
- Issue back-to-back, with rob 5 writing rd=x6 followed by an instruction reading x6 -> the second packet has qj_valid=1, qj=5. Issue rs1=x0 -> vj=0, qj_valid=0 regardless of RF.
- Assert clear while a stalled packet is held and in_valid=1 -> out_valid=0 next cycle, rf_set_dep_id=0. Hold rdy_in=0 for 2 cycles -> no accept and outputs unchanged.
